norm_pipe: RTL
==============

Name: norm_pipe

Overview:
- Two-stage pipelined left-normaliser that consumes the one-hot leading-one vector of the existing leading-zero detector.
- Each accepted word is shifted left until its MSB is 1. The block also emits the binary shift count and a zero flag.
- Sits between the leading-zero detector and the downstream exponent-adjust / rounding logic.
- Uses valid/ready handshakes on both sides, with full throughput of one word per cycle.

Parameters:
- W, 32, data width in bits; legal range 2 or more.
- SHIFT_W, $clog2(W), width of the shift-count output; derived, never overridden.

Ports:
- clk  input  1  clock, rising edge.
- rst  input  1  reset, synchronous, active-high.
- i_vld  input  1  upstream word valid.
- i_data  input  W  word to normalise.
- o_rdy  output  1  block can accept i_data this cycle.
- o_vld  output  1  normalised result valid.
- o_data  output  W  i_data shifted left by o_shift.
- o_shift  output  SHIFT_W  number of leading zeros of the word; 0 when zero.
- o_zero  output  1  word was all-zeros.
- i_rdy  input  1  downstream accepts result this cycle.

Behaviour:
- Transfer rules:
  - Input transfer occurs when i_vld & o_rdy.
  - Output transfer occurs when o_vld & i_rdy.
- Stage 1 (S1), on input transfer:
  - Registers i_data.
  - Registers the leading-zero detector one-hot result (MSB-first, detect-one), encoded to binary shift count.
  - Registers zero flag = ~|i_data.
- Stage 2 (S2):
  - Registers S1 data << S1 count, the count, and the zero flag.
  - S2 regs drive o_data/o_shift/o_zero directly; o_vld is the S2 valid flop.
- Stall/advance:
  - S2 loads when S1 valid and (~s2_vld | i_rdy).
  - S1 loads when i_vld and (~s1_vld | s2 loads).
  - o_rdy = ~s1_vld | ~s2_vld | i_rdy; purely combinational from state and i_rdy, no dependency on i_vld.
- Latency: 2 cycles from input transfer to o_vld when unstalled. Throughput: 1 word/cycle.
- Backpressure: while o_vld & ~i_rdy, o_data/o_shift/o_zero hold stable. S1 holds its word, and no new input is accepted once both stages are full.
- Simultaneous events: with both stages full and i_rdy=1, output transfer, S1->S2 move and new input acceptance all happen in the same cycle; no bubble.
- Data rules:
  - Zero input: o_data=0, o_shift=0, o_zero=1.
  - Nonzero input: o_data[W-1]=1, o_shift in 0..W-1, o_zero=0.
  - The shift is logical; vacated LSBs are filled with 0.
- Reset:
  - s1_vld=0, s2_vld=0, hence o_vld=0 and o_rdy=1.
  - o_data, o_shift and o_zero reset to 0.
  - Reset asserted mid-operation discards all in-flight words; no output transfer occurs in the reset cycle.
- No state machine beyond the two valid flops; illegal states do not exist.

Optional Feature:
- Macro: NORM_PIPE_PERF_EN.
- When defined, adds two ports:
  - o_perf_cnt (output, 32): number of output transfers.
  - o_zero_cnt (output, 32): number of output transfers with o_zero=1.
- Counters behave as follows:
  - Both reset to 0 on rst.
  - Both increment in the cycle of the transfer, so the new value is visible the next cycle.
  - Both wrap from 0xFFFF_FFFF to 0.
- When undefined, the ports and counters are absent. Datapath behaviour is identical in both builds.

Decomposition:
- Shared package holds:
  - norm_result_t struct {data, shift, zero}, parameterised via W in the package typedef convention.
  - Localparam helper for SHIFT_W.
- Reuses the existing leading-zero detector instance (FROM_LSB=0, DETECT_ZERO=0).
- One new sub-module: onehot_enc, a W-wide one-hot to $clog2(W)-bit binary encoder (OR-reduction form). It outputs 0 for an all-zero input.

Test Plan:
- W=8, i_rdy=1, single word 8'b0001_0110 -> 2 cycles later o_vld=1, o_data=8'b1011_0000, o_shift=3, o_zero=0.
- W=8, words 8'h00, 8'hFF, 8'h01 back-to-back with i_rdy=1:
  - o_zero=1 with o_data=0 and o_shift=0 for the first word.
  - o_shift=0 with o_data=8'hFF for the second.
  - o_shift=7 with o_data=8'h80 for the third.
  - Results on consecutive cycles, no bubbles.
- W=8, stream 4 words, hold i_rdy=0 for 5 cycles:
  - Outputs stable throughout.
  - o_rdy=0 after the 2nd word.
  - On i_rdy=1 the remaining words emerge in order, none lost or duplicated.
- Random i_vld/i_rdy, W=32, 10k words -> scoreboard matches a reference clz/shift model; o_rdy never depends on i_vld.
- Assert rst for 1 cycle with both stages full -> next cycle o_vld=0, o_rdy=1, outputs 0; the first post-reset word has 2-cycle latency.
- NORM_PIPE_PERF_EN defined: 6 transfers including 2 zero words -> o_perf_cnt=6, o_zero_cnt=2. Counter force-preloaded to 0xFFFF_FFFF wraps to 0 after one transfer.

Source files
------------

// File: rtl/norm_pipe_pkg.sv
// Shared types and width helpers for the two-stage left-normaliser.
package norm_pipe_pkg;

    localparam int NORM_W = 32;

    // Width of a shift count that can hold any value 0..w-1, never narrower than one bit.
    function automatic int shift_w(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

    localparam int NORM_SHIFT_W = shift_w(NORM_W);

    typedef struct packed {
        logic [NORM_W-1:0]       data;
        logic [NORM_SHIFT_W-1:0] shift;
        logic                    zero;
    } norm_result_t;

endpackage

// File: rtl/norm_pipe_if.sv
// Valid/ready bundles for the normaliser: word in on one side, normalised result out on the other.
import norm_pipe_pkg::*;

interface norm_pipe_in_if #(
    parameter int W = NORM_W
);
    logic         i_vld;
    logic [W-1:0] i_data;
    logic         o_rdy;

    modport master (output i_vld, output i_data, input o_rdy);
    modport slave  (input i_vld, input i_data, output o_rdy);
endinterface

interface norm_pipe_out_if #(
    parameter int W       = NORM_W,
    parameter int SHIFT_W = shift_w(W)
);
    logic               o_vld;
    logic [W-1:0]       o_data;
    logic [SHIFT_W-1:0] o_shift;
    logic               o_zero;
    logic               i_rdy;

    modport master (output o_vld, output o_data, output o_shift, output o_zero, input i_rdy);
    modport slave  (input o_vld, input o_data, input o_shift, input o_zero, output i_rdy);
endinterface

// File: rtl/norm_pipe_lzd.sv
// Leading-bit detector: onehot_o[k] marks the k-th scanned bit that is the first match.
// Scan starts at the MSB unless FROM_LSB; matches ones unless DETECT_ZERO.
module norm_pipe_lzd #(
    parameter int W           = 32,
    parameter bit FROM_LSB    = 1'b0,
    parameter bit DETECT_ZERO = 1'b0
) (
    input  logic [W-1:0] data_i,
    output logic [W-1:0] onehot_o
);

    // First-match priority scan; position k counts how many bits precede the match.
    always_comb begin
        logic found_s;
        logic bit_s;
        found_s  = 1'b0;
        bit_s    = 1'b0;
        onehot_o = '0;
        for (int k = 0; k < W; k++) begin
            bit_s       = data_i[FROM_LSB ? k : (W - 1 - k)] ^ DETECT_ZERO;
            onehot_o[k] = bit_s & ~found_s;
            found_s     = found_s | bit_s;
        end
    end

endmodule

// File: rtl/norm_pipe_onehot_enc.sv
// One-hot to binary encoder in OR-reduction form; an all-zero input encodes to 0.
import norm_pipe_pkg::*;

module onehot_enc #(
    parameter int W  = 32,
    parameter int BW = shift_w(W)
) (
    input  logic [W-1:0]  onehot_i,
    output logic [BW-1:0] bin_o
);

    // Bit b of the index is the OR of every one-hot line whose position has bit b set.
    always_comb begin
        bin_o = '0;
        for (int b = 0; b < BW; b++) begin
            for (int i = 0; i < W; i++) begin
                bin_o[b] = bin_o[b] | (onehot_i[i] & 1'(i >> b));
            end
        end
    end

endmodule

// File: rtl/norm_pipe.sv
// Two-stage left-normaliser: S1 captures word, leading-zero count and zero flag; S2 shifts.
// Define NORM_PIPE_PERF_EN to add output-transfer and zero-word counters.
module norm_pipe
    import norm_pipe_pkg::*;
#(
    parameter int W = NORM_W
) (
    input  logic            clk,
    input  logic            rst,
    norm_pipe_in_if.slave   in_if,
    norm_pipe_out_if.master out_if
`ifdef NORM_PIPE_PERF_EN
    ,
    output logic [31:0]     o_perf_cnt,
    output logic [31:0]     o_zero_cnt
`endif
);

    localparam int SHIFT_W = shift_w(W);

    typedef struct packed {
        logic [W-1:0]       data;
        logic [SHIFT_W-1:0] shift;
        logic               zero;
    } stage_t;

    logic [W-1:0]       lead_oh_s;
    logic [SHIFT_W-1:0] lead_cnt_s;

    logic s1_vld_q, s1_vld_d;
    logic s2_vld_q, s2_vld_d;
    stage_t s1_q, s1_d;
    stage_t s2_q, s2_d;

    logic s1_load_s, s2_load_s, out_xfer_s;

    norm_pipe_lzd #(
        .W           (W),
        .FROM_LSB    (1'b0),
        .DETECT_ZERO (1'b0)
    ) u_lzd (
        .data_i   (in_if.i_data),
        .onehot_o (lead_oh_s)
    );

    onehot_enc #(
        .W  (W),
        .BW (SHIFT_W)
    ) u_enc (
        .onehot_i (lead_oh_s),
        .bin_o    (lead_cnt_s)
    );

    // S2 drains on i_rdy, so S1 may refill in the same cycle it hands its word forward.
    always_comb begin
        s2_load_s  = s1_vld_q & (~s2_vld_q | out_if.i_rdy);
        s1_load_s  = in_if.i_vld & (~s1_vld_q | s2_load_s);
        out_xfer_s = s2_vld_q & out_if.i_rdy;
    end

    assign in_if.o_rdy    = ~s1_vld_q | ~s2_vld_q | out_if.i_rdy;
    assign out_if.o_vld   = s2_vld_q;
    assign out_if.o_data  = s2_q.data;
    assign out_if.o_shift = s2_q.shift;
    assign out_if.o_zero  = s2_q.zero;

    // S1 next state: capture the incoming word with its count, or empty once S2 takes it.
    always_comb begin
        s1_d     = s1_q;
        s1_vld_d = s1_vld_q;
        if (s1_load_s) begin
            s1_vld_d   = 1'b1;
            s1_d.data  = in_if.i_data;
            s1_d.shift = lead_cnt_s;
            s1_d.zero  = ~|in_if.i_data;
        end else if (s2_load_s) begin
            s1_vld_d = 1'b0;
        end else begin
            s1_vld_d = s1_vld_q;
        end
    end

    // S2 next state: a zero word has count 0, so the shift leaves it zero.
    always_comb begin
        s2_d     = s2_q;
        s2_vld_d = s2_vld_q;
        if (s2_load_s) begin
            s2_vld_d   = 1'b1;
            s2_d.data  = s1_q.data << s1_q.shift;
            s2_d.shift = s1_q.shift;
            s2_d.zero  = s1_q.zero;
        end else if (out_if.i_rdy) begin
            s2_vld_d = 1'b0;
        end else begin
            s2_vld_d = s2_vld_q;
        end
    end

    // Pipeline registers; reset empties both stages and clears the output word.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_vld_q <= 1'b0;
            s2_vld_q <= 1'b0;
            s1_q     <= '0;
            s2_q     <= '0;
        end else begin
            s1_vld_q <= s1_vld_d;
            s2_vld_q <= s2_vld_d;
            s1_q     <= s1_d;
            s2_q     <= s2_d;
        end
    end

`ifdef NORM_PIPE_PERF_EN
    logic [31:0] perf_cnt_q, perf_cnt_d;
    logic [31:0] zero_cnt_q, zero_cnt_d;

    // Free-running wrap-around counters of output transfers and of zero results among them.
    always_comb begin
        perf_cnt_d = perf_cnt_q;
        zero_cnt_d = zero_cnt_q;
        if (out_xfer_s) begin
            perf_cnt_d = perf_cnt_q + 32'd1;
            zero_cnt_d = zero_cnt_q + {31'd0, s2_q.zero};
        end else begin
            perf_cnt_d = perf_cnt_q;
            zero_cnt_d = zero_cnt_q;
        end
    end

    // Counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            perf_cnt_q <= 32'd0;
            zero_cnt_q <= 32'd0;
        end else begin
            perf_cnt_q <= perf_cnt_d;
            zero_cnt_q <= zero_cnt_d;
        end
    end

    assign o_perf_cnt = perf_cnt_q;
    assign o_zero_cnt = zero_cnt_q;
`endif

endmodule
